// File: rtl/seg7_pattern_decoder.sv
// Debounces an active-low 7-segment bus and reports each settled digit once.
// Define SEG7_DEC_ERRCNT_EN to add the saturating err_cnt output.
module seg7_pattern_decoder #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] h,
  input  logic       en,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [2:0] b,
  output logic       blank,
  output logic       err
`ifdef SEG7_DEC_ERRCNT_EN
  ,
  output logic [7:0] err_cnt
`endif
);

  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

  typedef enum logic {
    IDLE,
    VALID
  } state_e;

  state_e     state_q, state_d;
  logic [6:0] h_s_q, h_s_d;
  logic [6:0] cand_q, cand_d;
  logic [6:0] last_q, last_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] b_q, b_d;
  logic       blank_q, blank_d;
  logic       err_q, err_d;
  logic       stable;
  logic [2:0] dec_b;
  logic       dec_blank;
  logic       dec_err;

`ifdef SEG7_DEC_ERRCNT_EN
  logic [7:0] ecnt_q, ecnt_d;
`endif

  always_comb begin
    h_s_d  = en ? h : BLANK;
    cand_d = cand_q;
    cnt_d  = cnt_q;
    if (h_s_q != cand_q) begin
      cand_d = h_s_q;
      cnt_d  = 8'd0;
    end else if (cnt_q != CNT_LAST) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  assign stable = (h_s_q == cand_q) && (cnt_q == CNT_LAST);

  always_comb begin
    dec_b     = 3'd0;
    dec_blank = 1'b0;
    dec_err   = 1'b0;
    unique case (cand_q)
      7'b1000000: dec_b = 3'd0;
      7'b1111001: dec_b = 3'd1;
      7'b0100100: dec_b = 3'd2;
      7'b0110000: dec_b = 3'd3;
      7'b0011001: dec_b = 3'd4;
      7'b0010010: dec_b = 3'd5;
      7'b0000010: dec_b = 3'd6;
      7'b1111000: dec_b = 3'd7;
      BLANK:      dec_blank = 1'b1;
      default:    dec_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    b_d     = b_q;
    blank_d = blank_q;
    err_d   = err_q;
`ifdef SEG7_DEC_ERRCNT_EN
    ecnt_d  = ecnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (stable && (cand_q != last_q)) begin
          state_d = VALID;
          last_d  = cand_q;
          b_d     = dec_b;
          blank_d = dec_blank;
          err_d   = dec_err;
`ifdef SEG7_DEC_ERRCNT_EN
          if (dec_err && (ecnt_q != 8'hff)) ecnt_d = ecnt_q + 8'd1;
`endif
        end
      end
      VALID: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      h_s_q   <= BLANK;
      cand_q  <= BLANK;
      last_q  <= BLANK;
      cnt_q   <= 8'd0;
      b_q     <= 3'd0;
      blank_q <= 1'b0;
      err_q   <= 1'b0;
`ifdef SEG7_DEC_ERRCNT_EN
      ecnt_q  <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      h_s_q   <= h_s_d;
      cand_q  <= cand_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      b_q     <= b_d;
      blank_q <= blank_d;
      err_q   <= err_d;
`ifdef SEG7_DEC_ERRCNT_EN
      ecnt_q  <= ecnt_d;
`endif
    end
  end

  assign out_valid = (state_q == VALID);
  assign b         = b_q;
  assign blank     = blank_q;
  assign err       = err_q;
`ifdef SEG7_DEC_ERRCNT_EN
  assign err_cnt   = ecnt_q;
`endif

endmodule

// File: tb/tb_seg7_pattern_decoder.sv
// Scoreboard bench for seg7_pattern_decoder; reference model tracks run lengths.
// Honours SEG7_DEC_ERRCNT_EN for the optional error counter.
module tb_seg7_pattern_decoder;

  localparam int S = 4;
  localparam logic [6:0] BLK = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] h;
  logic       en;
  logic       out_ready;
  logic       out_valid;
  logic [2:0] b;
  logic       blank;
  logic       err;
`ifdef SEG7_DEC_ERRCNT_EN
  logic [7:0] err_cnt;
`endif

  seg7_pattern_decoder #(.STABLE_CYCLES(S)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .h        (h),
    .en       (en),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .b        (b),
    .blank    (blank),
    .err      (err)
`ifdef SEG7_DEC_ERRCNT_EN
    ,
    .err_cnt  (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [6:0] dig [8] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                          7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000};

  int checks = 0;
  int failures = 0;

  // expected report packed as {b, blank, err}
  logic [4:0] q[$];
  logic [6:0] m_prev;
  int         m_run;
  bit         m_busy;
  logic [6:0] m_last;
  int         m_ecnt;

  function automatic logic [4:0] ref_decode(input logic [6:0] p);
    for (int i = 0; i < 8; i++)
      if (dig[i] == p) return {3'(i), 1'b0, 1'b0};
    if (p == BLK) return 5'b000_1_0;
    return 5'b000_0_1;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a pattern is settled once S+1 consecutive samples agree.
  always @(posedge clk) begin
    logic [6:0] s;
    logic [4:0] e;
    if (!rst_n) begin
      m_prev = BLK;
      m_run  = 2;
      m_busy = 0;
      m_last = BLK;
      m_ecnt = 0;
      q.delete();
    end else begin
      if (m_busy) begin
        if (out_ready) m_busy = 0;
      end else if (m_run >= S + 1 && m_prev != m_last) begin
        e = ref_decode(m_prev);
        q.push_back(e);
        m_last = m_prev;
        m_busy = 1;
        if (e[0] && m_ecnt < 255) m_ecnt++;
      end
      s = en ? h : BLK;
      if (s == m_prev) begin
        if (m_run < 1000) m_run++;
      end else begin
        m_prev = s;
        m_run  = 1;
      end
    end
  end

  // Monitor
  always @(negedge clk) begin
    logic [4:0] e;
    if (rst_n === 1'b1) begin
      check("out_valid", int'(out_valid), int'(m_busy));
`ifdef SEG7_DEC_ERRCNT_EN
      check("err_cnt", int'(err_cnt), m_ecnt);
`endif
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("unexpected_report", 1, 0);
        end else begin
          e = q.pop_front();
          check("b", int'(b), int'(e[4:2]));
          check("blank", int'(blank), int'(e[1]));
          check("err", int'(err), int'(e[0]));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic [6:0] p, input int n, input logic rdy);
    h = p;
    out_ready = rdy;
    tick(n);
  endtask

  logic [6:0] p;
  int         kind;

  initial begin
    rst_n = 1'b0;
    h = BLK;
    en = 1'b1;
    out_ready = 1'b0;
    tick(2);
    check("rst_valid", int'(out_valid), 0);
    check("rst_b", int'(b), 0);
    check("rst_blank", int'(blank), 0);
    check("rst_err", int'(err), 0);
    rst_n = 1'b1;

    hold(7'b0100100, 12, 1'b0);
    hold(7'b0100100, 1, 1'b1);
    hold(7'b0100100, 3, 1'b0);

    hold(7'b1111001, 50, 1'b1);
    hold(7'b0000010, 3, 1'b1);
    hold(7'b1111000, 20, 1'b1);
    hold(7'b0000000, 20, 1'b1);
    hold(7'b0110000, 20, 1'b1);
    en = 1'b0;
    hold(7'b0110000, 20, 1'b1);
    en = 1'b1;

    hold(7'b0011001, 12, 1'b0);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    hold(7'b0011001, 12, 1'b0);
    hold(7'b0011001, 4, 1'b1);

    hold(dig[2], 2, 1'b1);
    hold(dig[5], 2, 1'b1);
    hold(dig[2], 12, 1'b1);

    for (int i = 0; i < 300; i++) begin
      hold(7'b0000000, 8, 1'b1);
      hold(BLK, 8, 1'b1);
    end

    for (int i = 0; i < 500; i++) begin
      kind = $urandom_range(0, 9);
      if (kind < 6) p = dig[$urandom_range(0, 7)];
      else if (kind < 8) p = BLK;
      else p = 7'($urandom);
      h = p;
      en = ($urandom_range(0, 9) != 0);
      repeat ($urandom_range(1, 10)) begin
        out_ready = 1'($urandom);
        tick(1);
      end
    end

    en = 1'b1;
    hold(h, 30, 1'b1);
    check("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
